// File: rtl/inst_fetch_resp_pkg.sv
// Shared constants and state encoding for the fetch responder.
package inst_fetch_resp_pkg;

    localparam int unsigned  DEPTH_DEFAULT      = 2;
    localparam logic [31:0]  RESET_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_FLUSHING = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_resp_fifo.sv
// Parameterised synchronous FIFO with synchronous clear and occupancy count.
// Clear wins over a push or pop in the same cycle.
module fetch_resp_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Qualify push/pop and compute next pointers; pointers wrap naturally.
    always_comb begin
        do_push = push_i & ~clear_i & (cnt_q != (PW+1)'(DEPTH));
        do_pop  = pop_i  & ~clear_i & (cnt_q != '0);
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are only meaningful while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: issues word-aligned reads, buffers in-order responses,
// squashes outstanding fetches on redirect and back-pressures the PC generator.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEFAULT,
    parameter logic [31:0] RESET_INST = RESET_INST_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] pc,
    input  logic        Fetch_Req,
    input  logic        Flush,
    input  logic        Consume,
    output logic        Fetch_Stall,
    output logic [31:0] Instruction__IF_ID,
    output logic        Inst_Valid__IF_ID,
    output logic        Fetch_Error__IF_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [1:0]  Fetch_State
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          ready_q;
    logic [CW-1:0] pend, pend_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt, cnt_d;
    fetch_state_e  state_q, state_d;

    logic          room, grant, rv_ok, rv_keep, rv_drop;
    logic          rsp_push, rsp_pop;
    logic          tag_mis;
    logic [32:0]   rsp_head;

    // Bus handshake and qualification of returning data.
    always_comb begin
        room     = ({1'b0, pend} + {1'b0, cnt}) < (CW+1)'(DEPTH);
        imem_req = ready_q & Fetch_Req & ~Flush & room;
        grant    = imem_req & imem_gnt;
        rv_ok    = imem_rvalid & (pend != '0);
        rv_drop  = rv_ok & (disc_q != '0);
        rv_keep  = rv_ok & (disc_q == '0);
        rsp_push = rv_keep & ~Flush;
        rsp_pop  = Consume & (cnt != '0) & ~Flush;
    end

    assign imem_addr   = {pc[31:2], 2'b00};
    assign Fetch_Stall = Fetch_Req & ~grant;

    // The tag FIFO holds exactly one entry per outstanding read, so its
    // occupancy is the pending count; no separate pend register is kept.
    fetch_resp_fifo #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (grant),
        .pop_i   (rv_ok),
        .clear_i (1'b0),
        .data_i  (pc[1:0] != 2'b00),
        .data_o  (tag_mis),
        .count_o (pend)
    );

    fetch_resp_fifo #(
        .WIDTH (33),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (rsp_push),
        .pop_i   (rsp_pop),
        .clear_i (Flush),
        .data_i  ({imem_rdata, imem_err | tag_mis}),
        .data_o  (rsp_head),
        .count_o (cnt)
    );

    // Next values of the pending, discard and buffered counts.
    always_comb begin
        pend_d = pend + CW'(grant) - CW'(rv_ok);
        disc_d = Flush ? pend_d : (disc_q - CW'(rv_drop));
        cnt_d  = Flush ? '0 : (cnt + CW'(rsp_push) - CW'(rsp_pop));
    end

    // Next-state logic for the debug status.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (Flush)
                    state_d = (pend_d != '0) ? ST_FLUSHING : ST_IDLE;
                else if (pend_d == '0 && cnt_d == '0)
                    state_d = ST_IDLE;
            end
            ST_FLUSHING: begin
                if (Flush)
                    state_d = (pend_d != '0) ? ST_FLUSHING : ST_IDLE;
                else if (disc_d == '0)
                    state_d = (pend_d != '0 || cnt_d != '0) ? ST_BUSY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready flag, discard count and state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ready_q <= 1'b0;
            disc_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            ready_q <= 1'b1;
            disc_q  <= disc_d;
            state_q <= state_d;
        end
    end

    // Head of the response FIFO drives IF_ID; idle slot shows a NOP.
    always_comb begin
        Inst_Valid__IF_ID  = (cnt != '0);
        Instruction__IF_ID = Inst_Valid__IF_ID ? rsp_head[32:1] : RESET_INST;
        Fetch_Error__IF_ID = Inst_Valid__IF_ID & rsp_head[0];
    end

    assign Fetch_State = state_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp: table-driven stream, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_fetch_resp;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RI    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] pc;
    logic        Fetch_Req, Flush, Consume;
    logic        Fetch_Stall;
    logic [31:0] Instruction__IF_ID;
    logic        Inst_Valid__IF_ID, Fetch_Error__IF_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [1:0]  Fetch_State;

    inst_fetch_resp #(.DEPTH(DEPTH), .RESET_INST(RI)) dut (
        .CLK(CLK), .RST_N(RST_N), .pc(pc), .Fetch_Req(Fetch_Req),
        .Flush(Flush), .Consume(Consume), .Fetch_Stall(Fetch_Stall),
        .Instruction__IF_ID(Instruction__IF_ID),
        .Inst_Valid__IF_ID(Inst_Valid__IF_ID),
        .Fetch_Error__IF_ID(Fetch_Error__IF_ID),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .imem_err(imem_err), .Fetch_State(Fetch_State)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int viol_cnt = 0;

    // Reference model: outstanding reads carry a "drop" flag set by a
    // redirect; buffered responses are kept in a plain queue.
    typedef struct { bit mis; bit drop; } tag_t;
    typedef struct { logic [31:0] data; bit err; } rsp_t;
    tag_t infl[$];
    rsp_t resp[$];
    bit   m_ready;

    typedef struct {
        logic        freq;
        logic        cons;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_inst;
    } vec_t;
    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic fr, input logic [31:0] p, input logic fl,
                         input logic co, input logic g, input logic rv,
                         input logic [31:0] d, input logic e);
        Fetch_Req = fr; pc = p; Flush = fl; Consume = co;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = d; imem_err = e;
    endtask

    task automatic mreset();
        infl.delete();
        resp.delete();
        m_ready = 1'b0;
    endtask

    // One cycle: inputs already driven after a negedge; compare, clock, update model.
    task automatic step();
        logic        e_req, e_stall, e_valid, e_ferr;
        logic [31:0] e_inst;
        logic [1:0]  e_st;
        bit          any_drop;
        tag_t        t;
        #1;
        e_req   = m_ready && Fetch_Req && !Flush && ((infl.size() + resp.size()) < DEPTH);
        e_stall = Fetch_Req && !(e_req && imem_gnt);
        e_valid = resp.size() > 0;
        e_inst  = e_valid ? resp[0].data : RI;
        e_ferr  = e_valid ? resp[0].err : 1'b0;
        any_drop = 1'b0;
        foreach (infl[i]) if (infl[i].drop) any_drop = 1'b1;
        e_st = any_drop ? 2'd2 : ((infl.size() + resp.size()) > 0 ? 2'd1 : 2'd0);
        check("imem_req", 32'(imem_req), 32'(e_req));
        check("imem_addr", imem_addr, {pc[31:2], 2'b00});
        check("Fetch_Stall", 32'(Fetch_Stall), 32'(e_stall));
        check("Inst_Valid", 32'(Inst_Valid__IF_ID), 32'(e_valid));
        check("Instruction", Instruction__IF_ID, e_inst);
        check("Fetch_Error", 32'(Fetch_Error__IF_ID), 32'(e_ferr));
        check("Fetch_State", 32'(Fetch_State), 32'(e_st));
        if (RST_N && imem_rvalid && infl.size() == 0) viol_cnt++;
        @(posedge CLK);
        if (RST_N) begin
            if (!Flush && Consume && resp.size() > 0) void'(resp.pop_front());
            if (imem_rvalid && infl.size() > 0) begin
                t = infl.pop_front();
                if (!t.drop && !Flush) resp.push_back('{imem_rdata, imem_err | t.mis});
            end
            if (Flush) begin
                resp.delete();
                foreach (infl[i]) infl[i].drop = 1'b1;
            end
            if (e_req && imem_gnt) infl.push_back('{pc[1:0] != 2'b00, 1'b0});
            m_ready = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        tbl = '{
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, RI},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, RI},
            '{1'b1, 1'b1, 1'b1, 32'h0050_0093, 1'b1, 1'b0, 1'b0, RI},
            '{1'b1, 1'b1, 1'b1, 32'h0060_0113, 1'b0, 1'b1, 1'b1, 32'h0050_0093},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0060_0113},
            '{1'b1, 1'b1, 1'b1, 32'h0070_0193, 1'b1, 1'b0, 1'b0, RI},
            '{1'b1, 1'b1, 1'b1, 32'h0080_0213, 1'b0, 1'b1, 1'b1, 32'h0070_0193},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0080_0213},
            '{1'b1, 1'b0, 1'b1, 32'h0090_0293, 1'b1, 1'b0, 1'b0, RI},
            '{1'b1, 1'b0, 1'b1, 32'h00a0_0313, 1'b0, 1'b1, 1'b1, 32'h0090_0293},
            '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0090_0293},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0090_0293},
            '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h00a0_0313},
            '{1'b1, 1'b0, 1'b1, 32'h00b0_0393, 1'b0, 1'b1, 1'b1, 32'h00a0_0313},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h00a0_0313},
            '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h00b0_0393},
            '{1'b0, 1'b1, 1'b1, 32'h00c0_0413, 1'b0, 1'b0, 1'b0, RI},
            '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h00c0_0413},
            '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, RI}
        };

        RST_N = 1'b0;
        mreset();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst Fetch_Stall", 32'(Fetch_Stall), 32'd1);
        check("rst Inst_Valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("rst Instruction", Instruction__IF_ID, RI);
        check("rst Fetch_Error", 32'(Fetch_Error__IF_ID), 32'd0);
        check("rst Fetch_State", 32'(Fetch_State), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Streaming and back-pressure, expectations worked out by hand.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].freq, 32'h0, 1'b0, tbl[i].cons, 1'b1, tbl[i].rv, tbl[i].rdata, 1'b0);
            #1;
            check($sformatf("tbl%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d stall", i), 32'(Fetch_Stall), 32'(tbl[i].e_stall));
            check($sformatf("tbl%0d valid", i), 32'(Inst_Valid__IF_ID), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d inst", i), Instruction__IF_ID, tbl[i].e_inst);
            check($sformatf("tbl%0d ferr", i), 32'(Fetch_Error__IF_ID), 32'd0);
            step();
        end

        // Redirect with two reads outstanding; both responses discarded.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h48, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        #1;
        check("flush valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("flush state", 32'(Fetch_State), 32'd2);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0); step();
        check("drop1 valid", 32'(Inst_Valid__IF_ID), 32'd0);
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0002, 1'b0); step();
        check("drop2 valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("post-drop state", 32'(Fetch_State), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0073, 1'b0); step();
        check("redirect valid", 32'(Inst_Valid__IF_ID), 32'd1);
        check("redirect inst", Instruction__IF_ID, 32'h0000_0073);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step();

        // Flush coinciding with rvalid and Consume: everything dropped.
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0); step();
        drive(1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 1'b0); step();
        check("flush+rv valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("flush+rv state", 32'(Fetch_State), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); step();
        check("flush+rv later valid", 32'(Inst_Valid__IF_ID), 32'd0);

        // Misaligned pc and bus error both flag Fetch_Error.
        drive(1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        check("misaligned addr", imem_addr, 32'h100);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0); step();
        check("mis ferr", 32'(Fetch_Error__IF_ID), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8765_4321, 1'b1); step();
        check("buserr ferr", 32'(Fetch_Error__IF_ID), 32'd1);
        check("buserr inst", Instruction__IF_ID, 32'h8765_4321);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); step();

        // Asynchronous reset while discarding two outstanding reads.
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
        check("pre-reset state", 32'(Fetch_State), 32'd2);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #3 RST_N = 1'b0;
        mreset();
        #1;
        check("async imem_req", 32'(imem_req), 32'd0);
        check("async Fetch_Stall", 32'(Fetch_Stall), 32'd1);
        check("async Inst_Valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("async Instruction", Instruction__IF_ID, RI);
        check("async Fetch_Error", 32'(Fetch_Error__IF_ID), 32'd0);
        check("async Fetch_State", 32'(Fetch_State), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_0001, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_0002, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); step();
        check("late rv valid", 32'(Inst_Valid__IF_ID), 32'd0);
        check("protocol violations seen", 32'(viol_cnt), 32'd2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                  (infl.size() > 0) && ($urandom_range(0, 1) == 1),
                  $urandom, $urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
